// File: rtl/time_display_mux.sv
// Four-digit multiplexed 7-segment driver for an HH:MM clock with per-frame
// input snapshot, group blinking, leading-zero suppression and registered pins.
module time_display_mux #(
    parameter int REFRESH_DIV  = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] hr_tens,
    input  logic [3:0] hr_ones,
    input  logic [3:0] min_tens,
    input  logic [3:0] min_ones,
    input  logic [1:0] blink_sel,
    input  logic       blank_lz,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; non-BCD codes render as a dark digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [RC_W-1:0] rc_q, rc_d;
    logic [1:0]      di_q, di_d;
    logic [FC_W-1:0] fc_q, fc_d;
    logic            bp_q, bp_d;
    // Snapshot layout {hr_tens, hr_ones, min_tens, min_ones} so nibble index equals di.
    logic [15:0]     snap_q, snap_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            digit_end;
    logic            frame_end;
    logic [3:0]      cur_digit;
    logic            blink_hit;
    logic            lz_hit;

    always_comb begin
        digit_end = (rc_q == RC_LAST);
        frame_end = digit_end && (di_q == 2'd3);

        rc_d   = digit_end ? '0 : rc_q + RC_W'(1);
        di_d   = digit_end ? di_q + 2'd1 : di_q;
        fc_d   = fc_q;
        bp_d   = bp_q;
        snap_d = snap_q;
        if (frame_end) begin
            snap_d = {hr_tens, hr_ones, min_tens, min_ones};
            if (fc_q == FC_LAST) begin
                fc_d = '0;
                bp_d = ~bp_q;
            end else begin
                fc_d = fc_q + FC_W'(1);
            end
        end
    end

    // Output stage: pins show the digit selected by this cycle's state, one clock later.
    always_comb begin
        cur_digit = snap_q[{di_q, 2'b00} +: 4];
        blink_hit = bp_q && ((blink_sel[0] && di_q[1]) || (blink_sel[1] && !di_q[1]));
        lz_hit    = blank_lz && (di_q == 2'd3) && (cur_digit == 4'd0);

        an_d  = ~(4'b0001 << di_q);
        seg_d = (blink_hit || lz_hit) ? SEG_BLANK : bcd_to_seg(cur_digit);
        dp_d  = !((di_q == 2'd2) && !bp_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rc_q   <= '0;
            di_q   <= 2'd0;
            fc_q   <= '0;
            bp_q   <= 1'b0;
            snap_q <= 16'h0000;
            an_q   <= 4'b1111;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
        end else begin
            rc_q   <= rc_d;
            di_q   <= di_d;
            fc_q   <= fc_d;
            bp_q   <= bp_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_time_display_mux.sv
// Scoreboard bench for time_display_mux: a frame/cycle arithmetic model queues
// the expected pins for each clock edge and a monitor compares after the edge.
module tb_time_display_mux;

    localparam int R  = 4;
    localparam int BF = 2;
    localparam int FR = 4 * R;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] hr_tens, hr_ones, min_tens, min_ones;
    logic [1:0] blink_sel;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    time_display_mux #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .reset    (reset),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .blink_sel(blink_sel),
        .blank_lz (blank_lz),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    logic [6:0]  seg_tab [16];
    logic [11:0] exp_q [$];
    logic [3:0]  snap [4];
    int          n;
    int          checks;
    int          failures;
    int          edge_no;
    bit          done;

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                    7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    end

    // Expected pins at the coming posedge, from elapsed cycles n since reset release.
    task automatic tick();
        logic [11:0] e;
        int          di, f, bp;
        logic [3:0]  v;
        bit          blank;
        if (reset) begin
            e = {4'b1111, 7'b1111111, 1'b1};
            n = 0;
            for (int k = 0; k < 4; k++) snap[k] = 4'd0;
        end else begin
            di = (n / R) % 4;
            f  = n / FR;
            bp = (f / BF) % 2;
            v  = snap[di];
            blank = (v > 4'd9)
                 || (bp == 1 && ((blink_sel[0] && di >= 2) || (blink_sel[1] && di < 2)))
                 || (di == 3 && blank_lz && v == 4'd0);
            e = {4'(~(1 << di)), blank ? 7'b1111111 : seg_tab[v], (di == 2 && bp == 0) ? 1'b0 : 1'b1};
            if (n % FR == FR - 1) begin
                snap[0] = min_ones;
                snap[1] = min_tens;
                snap[2] = hr_ones;
                snap[3] = hr_tens;
            end
            n++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 10000) begin
            tick();
            guard++;
        end
    endtask

    task automatic run_cycles(input int c);
        for (int k = 0; k < c; k++) tick();
    endtask

    task automatic set_time(input logic [3:0] ht, input logic [3:0] ho,
                            input logic [3:0] mt, input logic [3:0] mo);
        hr_tens  = ht;
        hr_ones  = ho;
        min_tens = mt;
        min_ones = mo;
    endtask

    task automatic chk_now(input string name, input logic [11:0] got, input logic [11:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Monitor: one comparison per clock edge against the queued expectation.
    initial begin
        logic [11:0] e;
        logic [11:0] got;
        edge_no = 0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (done) break;
            edge_no++;
            got = {an, seg, dp};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pins@%0d: got an=%b seg=%b dp=%b required (no expectation queued)",
                         edge_no, an, seg, dp);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failures++;
                    $display("FAIL pins@%0d: got an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                             edge_no, an, seg, dp, e[11:8], e[7:1], e[0]);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        done     = 1'b0;
        n        = 0;
        reset    = 1'b1;
        set_time(4'd0, 4'd0, 4'd0, 4'd0);
        blink_sel = 2'd0;
        blank_lz  = 1'b0;
        run_cycles(3);

        // Scan 12:34, then change minutes-ones in the middle of a frame.
        reset = 1'b0;
        set_time(4'd1, 4'd2, 4'd3, 4'd4);
        run_to(FR + R);
        min_ones = 4'd7;
        run_to(4 * FR);

        // Leading-zero suppression on 09:05.
        set_time(4'd0, 4'd9, 4'd0, 4'd5);
        blank_lz = 1'b1;
        run_cycles(2 * FR);
        blank_lz = 1'b0;
        run_cycles(2 * FR);

        // Blinking groups on 23:59.
        set_time(4'd2, 4'd3, 4'd5, 4'd9);
        blink_sel = 2'd1;
        run_cycles(8 * FR);
        blink_sel = 2'd2;
        run_cycles(4 * FR);
        blink_sel = 2'd3;
        run_cycles(4 * FR);

        // Invalid BCD digit.
        blink_sel = 2'd0;
        set_time(4'd1, 4'hC, 4'd3, 4'd0);
        run_cycles(2 * FR);

        // Reset mid-frame: pins go dark at once, then scan restarts from digit 0.
        run_to(n + (FR - n % FR) + 6);
        reset = 1'b1;
        #1;
        chk_now("reset_an", {8'd0, an}, {8'd0, 4'b1111});
        chk_now("reset_seg", {5'd0, seg}, {5'd0, 7'b1111111});
        chk_now("reset_dp", {11'd0, dp}, {11'd0, 1'b1});
        run_cycles(2);
        reset = 1'b0;
        set_time(4'd2, 4'd1, 4'd4, 4'd8);
        run_cycles(2 * FR);

        // Randomized activity including occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: hr_tens  = 4'($urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 11));
                    1: hr_ones  = 4'($urandom_range(0, 11));
                    2: min_tens = 4'($urandom_range(0, 11));
                    default: min_ones = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 39) == 0) blink_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) blank_lz = ~blank_lz;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        run_cycles(2);

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/time_display_mux.md
TIME_DISPLAY_MUX -- requirements
Module: time_display_mux

Interface
REQ-001 SHALL provide parameter REFRESH_DIV, default 1000, number of clk cycles each digit is driven (minimum 2).
REQ-002 SHALL provide parameter BLINK_FRAMES, default 125, number of full 4-digit scan frames per blink half-period (minimum 1).
REQ-003 SHALL provide port clk  input  1  system clock; all state updates on posedge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide ports hr_tens, hr_ones, min_tens, min_ones  input  4 each  BCD time digits from the hour and minute counters.
REQ-006 SHALL provide port blink_sel  input  2  blink group: 0 none, 1 hours, 2 minutes, 3 both.
REQ-007 SHALL provide port blank_lz  input  1  when 1, suppress a zero hours-tens digit.
REQ-008 SHALL provide port an  output  4  active-low digit enables; an[0] = minutes-ones (rightmost), an[3] = hours-tens.
REQ-009 SHALL provide port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL provide port dp  output  1  active-low decimal point, used as the hours/minutes separator.

Function
REQ-011 SHALL hold a refresh counter rc counting 0..REFRESH_DIV-1, wrapping to 0.
REQ-012 SHALL hold a digit index di (0..3); di SHALL advance by 1 (3 wraps to 0) on the cycle rc = REFRESH_DIV-1.
REQ-013 SHALL capture all four BCD inputs into a snapshot register on the cycle rc = REFRESH_DIV-1 and di = 3 (end of frame); digits displayed within one frame SHALL never mix values from different cycles.
REQ-014 SHALL hold a frame counter fc (0..BLINK_FRAMES-1) advancing at each end of frame, and a blink phase bp that toggles when fc wraps.
REQ-015 SHALL select the snapshot digit by di: 0 min_ones, 1 min_tens, 2 hr_ones, 3 hr_tens.
REQ-016 SHALL decode BCD 0-9 to: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL drive seg=1111111 (blank) for any snapshot value 10-15.
REQ-018 SHALL blank the digit (seg=1111111, an still asserted) when bp=1 and di is in the group selected by blink_sel (hours: di 2,3; minutes: di 0,1).
REQ-019 SHALL blank digit 3 when blank_lz=1 and the snapshot hr_tens = 0.
REQ-020 SHALL assert dp=0 only when di=2 and bp=0; otherwise dp=1.
REQ-021 SHALL register an, seg, dp: the pins SHALL reflect the di/rc state of the previous cycle (1-cycle latency), with exactly one an bit low after reset release.
REQ-022 SHALL sample blink_sel and blank_lz live (not snapshotted); a change takes effect on the next registered output update.

Reset
REQ-023 SHALL, while reset=1, force rc=0, di=0, fc=0, bp=0, snapshot=0, an=1111, seg=1111111, dp=1, regardless of clk.
REQ-024 SHALL, on the first posedge after reset release, drive an=1110 and seg=1000000 (snapshot 0), until the first end of frame loads real inputs.
REQ-025 SHALL, on reset asserted mid-frame, abandon the frame immediately and restart from REQ-024 behaviour.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-026 Scan: inputs 12:34, blink_sel=0, blank_lz=0, run 2 frames -> second frame an cycles 1110,1101,1011,0111 four cycles each with seg 0011001,0110000,0100100,1111001.
REQ-027 Snapshot: change min_ones 4->7 during di=1 of frame 2 -> digit 0 shows 4 for rest of frame 2, 7 from frame 3.
REQ-028 Leading zero: inputs 09:05, blank_lz=1 -> an=0111 phase shows seg=1111111; with blank_lz=0 shows 1000000.
REQ-029 Blink: blink_sel=1, inputs 23:59 -> digits 2,3 blank in frames with bp=1 (frames 3-4, 7-8 after reset), minutes always lit; dp=0 during di=2 only when bp=0.
REQ-030 Invalid/reset: hr_ones=4'hC -> digit 2 blank; assert reset mid-frame -> an=1111, seg=1111111, dp=1 immediately, then REQ-024 sequence after release.
